// File: rtl/psum_burst_writer.sv
// psum_burst_writer: saturates the 4-lane systolic partial-sum stream to int16.
// It packs each beat into a 64-bit word and buffers the words in a
// first-word-fall-through FIFO. It then drains the FIFO to DDR as burst
// writes: full bursts while enough data is buffered, and one partial burst
// on flush.
module psum_burst_writer #(
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 8,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int ADDR_STEP  = 8,
    localparam int SYSTOLIC_PSUM_WIDTH = 80,
    localparam int DATA_WIDTH = 64
) (
    input  logic                           s_clk,
    input  logic                           s_rst,
    input  logic [SYSTOLIC_PSUM_WIDTH-1:0] i_PsumData,
    input  logic                           i_PsumValid,
    input  logic                           i_Psum_Finish,
    output logic                           o_PsumReady,
    output logic [DATA_WIDTH-1:0]          o_burst_write_data,
    output logic [ADDR_SIZE-1:0]           o_burst_write_addr,
    output logic [LEN_WIDTH-1:0]           o_burst_write_len,
    output logic                           o_burst_write_req,
    input  logic                           i_burst_write_valid,
    input  logic                           i_burst_write_finish,
    output logic                           o_WrDone,
    output logic                           o_Overflow
);

    localparam int LANES   = 4;
    localparam int PSUM_W  = 20;
    localparam int OUT_W   = 16;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    // Clamp a signed 20-bit partial sum into the int16 range.
    function automatic logic signed [OUT_W-1:0] satInt16(input logic signed [PSUM_W-1:0] x);
        logic signed [PSUM_W-1:0] satMax;
        logic signed [PSUM_W-1:0] satMin;
        satMax = 20'sd32767;
        satMin = -20'sd32768;
        if (x > satMax)
            return 16'sh7FFF;
        else if (x < satMin)
            return 16'sh8000;
        else
            return x[OUT_W-1:0];
    endfunction

    state_t                 state;
    logic                   vld_p1;
    logic                   finish_p1;
    logic [DATA_WIDTH-1:0]  packedWord_p1;
    logic                   flushPending;

    logic [DATA_WIDTH-1:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr;
    logic [PTR_W-1:0]       rdPtr;
    logic [CNT_W-1:0]       fifoCount;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   fifoPush;
    logic                   fifoPop;

    assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (fifoCount == '0);
    assign fifoPush  = vld_p1 && !fifoFull;
    assign fifoPop   = (state == S_BURST) && i_burst_write_valid && !fifoEmpty;

    assign o_PsumReady        = !fifoFull;
    assign o_burst_write_data = fifoEmpty ? '0 : fifoMem[rdPtr];

    // ---- stage p1: saturate and pack the incoming lanes ----
    // Pack-stage data register; carries no reset, validity lives in vld_p1.
    always_ff @(posedge s_clk) begin
        for (int k = 0; k < LANES; k++)
            packedWord_p1[OUT_W*k +: OUT_W] <= satInt16(i_PsumData[PSUM_W*k +: PSUM_W]);
    end

    // Pack-stage control: valid and the finish pulse travel with the data.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            vld_p1    <= 1'b0;
            finish_p1 <= 1'b0;
        end else begin
            vld_p1    <= i_PsumValid;
            finish_p1 <= i_Psum_Finish;
        end
    end

    // ---- stage p2: FIFO write ----
    // FIFO storage; a word arriving while full is dropped.
    always_ff @(posedge s_clk) begin
        if (fifoPush)
            fifoMem[wrPtr] <= packedWord_p1;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (fifoPush)
                wrPtr <= wrPtr + 1'b1;
            if (fifoPop)
                rdPtr <= rdPtr + 1'b1;
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (vld_p1 && fifoFull)
                o_Overflow <= 1'b1;
        end
    end

    // Burst-write FSM: issues full bursts, a partial burst on flush, then the done pulse.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state              <= S_IDLE;
            o_burst_write_req  <= 1'b0;
            o_burst_write_addr <= BASE_ADDR;
            o_burst_write_len  <= '0;
            o_WrDone           <= 1'b0;
            flushPending       <= 1'b0;
        end else begin
            o_WrDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fifoCount >= CNT_W'(BURST_LEN)) begin
                        o_burst_write_len <= LEN_WIDTH'(BURST_LEN);
                        o_burst_write_req <= 1'b1;
                        state             <= S_BURST;
                    end else if (flushPending && !fifoEmpty) begin
                        o_burst_write_len <= LEN_WIDTH'(fifoCount);
                        o_burst_write_req <= 1'b1;
                        state             <= S_BURST;
                    end else if (flushPending) begin
                        o_WrDone           <= 1'b1;
                        o_burst_write_addr <= BASE_ADDR;
                        state              <= S_DONE;
                    end
                end
                S_BURST: begin
                    if (i_burst_write_finish) begin
                        o_burst_write_req  <= 1'b0;
                        o_burst_write_addr <= o_burst_write_addr
                                            + ADDR_SIZE'(o_burst_write_len) * ADDR_SIZE'(ADDR_STEP);
                        state              <= S_IDLE;
                    end
                end
                S_DONE: begin
                    o_burst_write_addr <= BASE_ADDR;
                    state              <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A finish landing while the done state retires belongs to the next stream.
            if (finish_p1)
                flushPending <= 1'b1;
            else if (state == S_DONE)
                flushPending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_burst_writer.sv
// Directed bench for psum_burst_writer with a behavioural DDR burst responder.
module tb_psum_burst_writer;

    localparam int ADDR_SIZE  = 32;
    localparam int LEN_WIDTH  = 8;
    localparam int BURST_LEN  = 64;
    localparam int FIFO_DEPTH = 128;
    localparam int ADDR_STEP  = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b0;
    logic [79:0] i_PsumData = '0;
    logic        i_PsumValid = 1'b0;
    logic        i_Psum_Finish = 1'b0;
    logic        o_PsumReady;
    logic [63:0] o_burst_write_data;
    logic [31:0] o_burst_write_addr;
    logic [7:0]  o_burst_write_len;
    logic        o_burst_write_req;
    logic        i_burst_write_valid = 1'b0;
    logic        i_burst_write_finish = 1'b0;
    logic        o_WrDone;
    logic        o_Overflow;

    psum_burst_writer #(
        .ADDR_SIZE(ADDR_SIZE), .LEN_WIDTH(LEN_WIDTH), .BASE_ADDR(BASE),
        .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .i_PsumData(i_PsumData), .i_PsumValid(i_PsumValid), .i_Psum_Finish(i_Psum_Finish),
        .o_PsumReady(o_PsumReady),
        .o_burst_write_data(o_burst_write_data), .o_burst_write_addr(o_burst_write_addr),
        .o_burst_write_len(o_burst_write_len), .o_burst_write_req(o_burst_write_req),
        .i_burst_write_valid(i_burst_write_valid), .i_burst_write_finish(i_burst_write_finish),
        .o_WrDone(o_WrDone), .o_Overflow(o_Overflow)
    );

    always #5 s_clk = ~s_clk;

    int vectors = 0;
    int miscompares = 0;

    // DDR responder state and logs
    bit          ddrEn = 1'b0;
    bit          inBurst = 1'b0;
    logic [31:0] curAddr = '0;
    int          curLen = 0;
    int          beatsDone = 0;
    int          nBursts = 0;
    logic [31:0] bAddr [64];
    int          bLen [64];
    logic [63:0] ddrMem [1024];
    int          wrDoneCnt = 0;
    int          reqCnt = 0;

    function automatic logic [79:0] genPsum(int k, int seed);
        logic [79:0] p;
        int v;
        p = '0;
        for (int j = 0; j < 4; j++) begin
            v = ((k * 37 + j * 11 + seed * 101) % 2001) - 1000;
            p[20*j +: 20] = v[19:0];
        end
        return p;
    endfunction

    function automatic logic [63:0] genExp(int k, int seed);
        logic [63:0] w;
        int v;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            v = ((k * 37 + j * 11 + seed * 101) % 2001) - 1000;
            w[16*j +: 16] = v[15:0];
        end
        return w;
    endfunction

    // Responder: one beat per cycle while req is up, then a one-cycle finish.
    initial begin : responder
        int idx;
        forever begin
            @(posedge s_clk);
            #1;
            if (o_burst_write_req !== 1'b1) begin
                i_burst_write_valid  = 1'b0;
                i_burst_write_finish = 1'b0;
                inBurst = 1'b0;
            end else if (!ddrEn) begin
                i_burst_write_valid  = 1'b0;
                i_burst_write_finish = 1'b0;
            end else begin
                if (!inBurst) begin
                    inBurst   = 1'b1;
                    curAddr   = o_burst_write_addr;
                    curLen    = int'(o_burst_write_len);
                    beatsDone = 0;
                    bAddr[nBursts % 64] = curAddr;
                    bLen[nBursts % 64]  = curLen;
                    nBursts++;
                end
                if (beatsDone < curLen) begin
                    i_burst_write_valid  = 1'b1;
                    i_burst_write_finish = 1'b0;
                    idx = int'(((curAddr - BASE) >> 3) & 32'h3FF);
                    ddrMem[(idx + beatsDone) % 1024] = o_burst_write_data;
                    beatsDone++;
                end else begin
                    i_burst_write_valid  = 1'b0;
                    i_burst_write_finish = 1'b1;
                end
            end
        end
    end

    always @(negedge s_clk) begin
        if (o_WrDone === 1'b1) wrDoneCnt++;
        if (o_burst_write_req === 1'b1) reqCnt++;
    end

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        s_rst = 1'b1;
        i_PsumValid = 1'b0;
        i_Psum_Finish = 1'b0;
        i_PsumData = '0;
        tick();
        s_rst = 1'b0;
        @(negedge s_clk);
    endtask

    task automatic pushStream(int n, int seed, bit finLast);
        for (int k = 0; k < n; k++) begin
            tick();
            i_PsumValid   = 1'b1;
            i_PsumData    = genPsum(k, seed);
            i_Psum_Finish = finLast && (k == n - 1);
        end
        tick();
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
    endtask

    task automatic pulseFinish();
        tick();
        i_Psum_Finish = 1'b1;
        tick();
        i_Psum_Finish = 1'b0;
    endtask

    task automatic waitDone(int base, int maxc);
        for (int c = 0; c < maxc && wrDoneCnt == base; c++)
            @(negedge s_clk);
        repeat (3) @(negedge s_clk);
    endtask

    task automatic checkResetOutputs(string tag);
        vectors++; if (o_burst_write_req !== 1'b0) begin miscompares++; $display("FAIL %s req: got %b want 0", tag, o_burst_write_req); end
        vectors++; if (o_burst_write_addr !== BASE) begin miscompares++; $display("FAIL %s addr: got %h want %h", tag, o_burst_write_addr, BASE); end
        vectors++; if (o_burst_write_len !== 8'd0) begin miscompares++; $display("FAIL %s len: got %0d want 0", tag, o_burst_write_len); end
        vectors++; if (o_WrDone !== 1'b0) begin miscompares++; $display("FAIL %s wrdone: got %b want 0", tag, o_WrDone); end
        vectors++; if (o_Overflow !== 1'b0) begin miscompares++; $display("FAIL %s overflow: got %b want 0", tag, o_Overflow); end
        vectors++; if (o_PsumReady !== 1'b1) begin miscompares++; $display("FAIL %s ready: got %b want 1", tag, o_PsumReady); end
        vectors++; if (o_burst_write_data !== 64'd0) begin miscompares++; $display("FAIL %s data: got %h want 0", tag, o_burst_write_data); end
    endtask

    task automatic test_reset();
        doReset();
        checkResetOutputs("reset");
    endtask

    // Saturation at and beyond the int16 limits; finish arrives with the last word.
    task automatic test_saturation();
        int base, sb;
        doReset();
        ddrEn = 1'b0;
        tick();
        i_PsumValid = 1'b1;
        i_PsumData  = {20'hFFFFE, 20'h00123, 20'h80000, 20'h7FFFF};
        tick();
        i_PsumData    = {20'h07FFF, 20'hF8000, 20'h08000, 20'hF7FFF};
        i_Psum_Finish = 1'b1;
        tick();
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
        repeat (4) @(negedge s_clk);
        vectors++; if (o_burst_write_data !== 64'hFFFE_0123_8000_7FFF) begin miscompares++; $display("FAIL sat_head: got %h want %h", o_burst_write_data, 64'hFFFE_0123_8000_7FFF); end
        vectors++; if (o_burst_write_len !== 8'd2) begin miscompares++; $display("FAIL sat_len: got %0d want 2", o_burst_write_len); end
        base = wrDoneCnt;
        sb = nBursts;
        ddrEn = 1'b1;
        waitDone(base, 50);
        vectors++; if (nBursts - sb !== 1) begin miscompares++; $display("FAIL sat_bursts: got %0d want 1", nBursts - sb); end
        vectors++; if (bAddr[sb % 64] !== BASE) begin miscompares++; $display("FAIL sat_addr: got %h want %h", bAddr[sb % 64], BASE); end
        vectors++; if (ddrMem[0] !== 64'hFFFE_0123_8000_7FFF) begin miscompares++; $display("FAIL sat_word0: got %h want %h", ddrMem[0], 64'hFFFE_0123_8000_7FFF); end
        vectors++; if (ddrMem[1] !== 64'h7FFF_8000_7FFF_8000) begin miscompares++; $display("FAIL sat_word1: got %h want %h", ddrMem[1], 64'h7FFF_8000_7FFF_8000); end
        vectors++; if (wrDoneCnt - base !== 1) begin miscompares++; $display("FAIL sat_wrdone: got %0d want 1", wrDoneCnt - base); end
    endtask

    task automatic test_full_bursts();
        int base, sb;
        doReset();
        ddrEn = 1'b1;
        base = wrDoneCnt;
        sb = nBursts;
        pushStream(128, 3, 1'b0);
        repeat (200) @(negedge s_clk);
        vectors++; if (nBursts - sb !== 2) begin miscompares++; $display("FAIL full_bursts: got %0d want 2", nBursts - sb); end
        vectors++; if (bAddr[sb % 64] !== BASE || bLen[sb % 64] !== 64) begin miscompares++; $display("FAIL full_b0: got %h/%0d want %h/64", bAddr[sb % 64], bLen[sb % 64], BASE); end
        vectors++; if (bAddr[(sb + 1) % 64] !== BASE + 32'd512 || bLen[(sb + 1) % 64] !== 64) begin miscompares++; $display("FAIL full_b1: got %h/%0d want %h/64", bAddr[(sb + 1) % 64], bLen[(sb + 1) % 64], BASE + 32'd512); end
        for (int k = 0; k < 128; k++) begin
            vectors++; if (ddrMem[k] !== genExp(k, 3)) begin miscompares++; $display("FAIL full_word%0d: got %h want %h", k, ddrMem[k], genExp(k, 3)); end
        end
        vectors++; if (wrDoneCnt - base !== 0) begin miscompares++; $display("FAIL full_wrdone: got %0d want 0", wrDoneCnt - base); end
        vectors++; if (o_burst_write_addr !== BASE + 32'd1024) begin miscompares++; $display("FAIL full_nextaddr: got %h want %h", o_burst_write_addr, BASE + 32'd1024); end
    endtask

    task automatic test_partial_flush();
        int base, sb;
        doReset();
        ddrEn = 1'b1;
        base = wrDoneCnt;
        sb = nBursts;
        pushStream(70, 5, 1'b0);
        pulseFinish();
        waitDone(base, 400);
        repeat (5) @(negedge s_clk);
        vectors++; if (nBursts - sb !== 2) begin miscompares++; $display("FAIL part_bursts: got %0d want 2", nBursts - sb); end
        vectors++; if (bAddr[sb % 64] !== BASE || bLen[sb % 64] !== 64) begin miscompares++; $display("FAIL part_b0: got %h/%0d want %h/64", bAddr[sb % 64], bLen[sb % 64], BASE); end
        vectors++; if (bAddr[(sb + 1) % 64] !== BASE + 32'd512 || bLen[(sb + 1) % 64] !== 6) begin miscompares++; $display("FAIL part_b1: got %h/%0d want %h/6", bAddr[(sb + 1) % 64], bLen[(sb + 1) % 64], BASE + 32'd512); end
        for (int k = 0; k < 70; k++) begin
            vectors++; if (ddrMem[k] !== genExp(k, 5)) begin miscompares++; $display("FAIL part_word%0d: got %h want %h", k, ddrMem[k], genExp(k, 5)); end
        end
        vectors++; if (wrDoneCnt - base !== 1) begin miscompares++; $display("FAIL part_wrdone: got %0d want 1", wrDoneCnt - base); end
        vectors++; if (o_burst_write_addr !== BASE) begin miscompares++; $display("FAIL part_addr: got %h want %h", o_burst_write_addr, BASE); end
    endtask

    task automatic test_finish_empty();
        logic seen [1:4];
        int base, rb;
        doReset();
        ddrEn = 1'b1;
        base = wrDoneCnt;
        rb = reqCnt;
        tick();
        i_Psum_Finish = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge s_clk);
            #1;
            if (c == 1) i_Psum_Finish = 1'b0;
            @(negedge s_clk);
            seen[c] = o_WrDone;
        end
        repeat (4) @(negedge s_clk);
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (seen[c] !== (c == 3)) begin miscompares++; $display("FAIL empty_wrdone_c%0d: got %b want %b", c, seen[c], (c == 3)); end
        end
        vectors++; if (reqCnt - rb !== 0) begin miscompares++; $display("FAIL empty_req: got %0d req cycles want 0", reqCnt - rb); end
        vectors++; if (wrDoneCnt - base !== 1) begin miscompares++; $display("FAIL empty_pulses: got %0d want 1", wrDoneCnt - base); end
    endtask

    task automatic test_finish_same_cycle();
        int base, sb;
        doReset();
        ddrEn = 1'b1;
        base = wrDoneCnt;
        sb = nBursts;
        pushStream(3, 8, 1'b1);
        waitDone(base, 50);
        vectors++; if (nBursts - sb !== 1 || bLen[sb % 64] !== 3) begin miscompares++; $display("FAIL same_burst: got %0d bursts len %0d want 1/3", nBursts - sb, bLen[sb % 64]); end
        vectors++; if (ddrMem[2] !== genExp(2, 8)) begin miscompares++; $display("FAIL same_lastword: got %h want %h", ddrMem[2], genExp(2, 8)); end
        vectors++; if (wrDoneCnt - base !== 1) begin miscompares++; $display("FAIL same_wrdone: got %0d want 1", wrDoneCnt - base); end
    endtask

    task automatic test_overflow();
        int base, sb;
        doReset();
        ddrEn = 1'b0;
        pushStream(128, 7, 1'b0);
        tick();
        @(negedge s_clk);
        vectors++; if (o_PsumReady !== 1'b0) begin miscompares++; $display("FAIL ovf_ready_full: got %b want 0", o_PsumReady); end
        vectors++; if (o_Overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_flag_early: got %b want 0", o_Overflow); end
        vectors++; if (o_burst_write_req !== 1'b1 || o_burst_write_len !== 8'd64) begin miscompares++; $display("FAIL ovf_req: got %b/%0d want 1/64", o_burst_write_req, o_burst_write_len); end
        pushStream(2, 9, 1'b0);
        tick();
        @(negedge s_clk);
        vectors++; if (o_Overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", o_Overflow); end
        base = wrDoneCnt;
        sb = nBursts;
        ddrEn = 1'b1;
        pulseFinish();
        waitDone(base, 400);
        vectors++; if (nBursts - sb !== 2) begin miscompares++; $display("FAIL ovf_bursts: got %0d want 2", nBursts - sb); end
        for (int k = 0; k < 128; k++) begin
            vectors++; if (ddrMem[k] !== genExp(k, 7)) begin miscompares++; $display("FAIL ovf_word%0d: got %h want %h", k, ddrMem[k], genExp(k, 7)); end
        end
        vectors++; if (wrDoneCnt - base !== 1) begin miscompares++; $display("FAIL ovf_wrdone: got %0d want 1", wrDoneCnt - base); end
        vectors++; if (o_Overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", o_Overflow); end
        vectors++; if (o_PsumReady !== 1'b1) begin miscompares++; $display("FAIL ovf_ready_drained: got %b want 1", o_PsumReady); end
        doReset();
        vectors++; if (o_Overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared: got %b want 0", o_Overflow); end
    endtask

    task automatic test_reset_mid_burst();
        int sb, sb2;
        bit started;
        doReset();
        ddrEn = 1'b1;
        sb = nBursts;
        pushStream(64, 11, 1'b0);
        started = 1'b0;
        for (int c = 0; c < 100 && !started; c++) begin
            @(negedge s_clk);
            started = (nBursts > sb) && (beatsDone >= 10);
        end
        vectors++; if (!started) begin miscompares++; $display("FAIL mid_start: got beats %0d want >= 10", beatsDone); end
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        @(negedge s_clk);
        checkResetOutputs("mid_reset");
        sb2 = nBursts;
        pushStream(64, 13, 1'b0);
        repeat (100) @(negedge s_clk);
        vectors++; if (nBursts - sb2 !== 1) begin miscompares++; $display("FAIL mid_bursts: got %0d want 1", nBursts - sb2); end
        vectors++; if (bAddr[sb2 % 64] !== BASE || bLen[sb2 % 64] !== 64) begin miscompares++; $display("FAIL mid_b0: got %h/%0d want %h/64", bAddr[sb2 % 64], bLen[sb2 % 64], BASE); end
        for (int k = 0; k < 64; k++) begin
            vectors++; if (ddrMem[k] !== genExp(k, 13)) begin miscompares++; $display("FAIL mid_word%0d: got %h want %h", k, ddrMem[k], genExp(k, 13)); end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ddrMem[i] = '0;
        for (int i = 0; i < 64; i++) begin bAddr[i] = '0; bLen[i] = 0; end
        test_reset();
        test_saturation();
        test_full_bursts();
        test_partial_flush();
        test_finish_empty();
        test_finish_same_cycle();
        test_overflow();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psum_burst_writer.md
# psum_burst_writer

Write-back engine for systolic-array results. It takes the 4-lane partial-sum stream that `SystolicController` produces (`o_PsumData` / `o_PsumValid` / `o_Psum_Finish`) and saturates each 20-bit lane to int16. It packs the lanes into `DATA_WIDTH` words, buffers them in a first-word-fall-through FIFO, and acts as the burst-write initiator toward `ddr_sim_spikformer` / DDR on the `burst_write_*` port. This is the write-side counterpart of `weight_fifo_v1`, which initiates burst reads on the same interface.

## Interface
Parameters:
- `BASE_ADDR`, default `'d0`: DDR byte address of the first output word. The write pointer returns here after every `o_WrDone`.
- `BURST_LEN`, default 64: words per full burst. Must be at most `2^LEN_WIDTH - 1`.
- `FIFO_DEPTH`, default 128: buffer depth in words. Must be a power of two and at least 2×`BURST_LEN`.
- `ADDR_STEP`, default 8: bytes per `DATA_WIDTH` word.

Ports (clock and reset first):
- `s_clk`  in  1  system clock.
- `s_rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `i_PsumData`  in  `SYSTOLIC_PSUM_WIDTH` (80)  four signed 20-bit lanes. Lane k occupies `[20k+19:20k]`.
- `i_PsumValid`  in  1  qualifies `i_PsumData`.
- `i_Psum_Finish`  in  1  single-cycle pulse marking the end of the result stream.
- `o_PsumReady`  out  1  FIFO not full; used as advisory backpressure.
- `o_burst_write_data`  out  `DATA_WIDTH` (64)  FIFO head word (FWFT).
- `o_burst_write_addr`  out  `ADDR_SIZE`  burst start byte address.
- `o_burst_write_len`  out  `LEN_WIDTH`  burst word count.
- `o_burst_write_req`  out  1  burst request.
- `i_burst_write_valid`  in  1  responder consumes the data word presented in this cycle.
- `i_burst_write_finish`  in  1  responder signals the burst is complete.
- `o_WrDone`  out  1  one-cycle pulse: every word of the stream has been written.
- `o_Overflow`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
Pack stage (registered, 1 cycle):
- Each lane is saturated to int16: values above 32767 become 32767, values below -32768 become -32768, and all others pass through unchanged.
- Lane k is placed in output bits `[16k+15:16k]`.
- The packed word is written into the FIFO the cycle after `i_PsumValid`.
- If the FIFO is full when the packed word arrives, the word is dropped and `o_Overflow` is set. It clears only on reset.

Flush tracking:
- `i_Psum_Finish` is delayed by one cycle to align with the pack stage, then sets `flush_pending`.
- A valid word that arrives in the same cycle as the finish pulse belongs to the flushed stream.

FSM states: `S_IDLE`, `S_BURST`, `S_DONE`.
- From `S_IDLE`:
  - If FIFO count ≥ `BURST_LEN`: latch len = `BURST_LEN` and go to `S_BURST`.
  - Else, if `flush_pending` and count > 0: latch len = count and go to `S_BURST` (partial burst).
  - Else, if `flush_pending` and count = 0: go to `S_DONE`.
  - Otherwise stay in `S_IDLE`.
- In `S_BURST`:
  - `req` is held at 1, with `addr` and `len` stable.
  - Each `i_burst_write_valid` pops the FIFO head; the next word appears on `o_burst_write_data` in the same cycle (FWFT).
  - On `i_burst_write_finish`: deassert `req`, advance addr by len×`ADDR_STEP`, and return to `S_IDLE`.
- In `S_DONE`:
  - `o_WrDone` is 1 for exactly one cycle.
  - `flush_pending` is cleared and addr is reset to `BASE_ADDR`.
  - The FSM then goes to `S_IDLE`.

Other rules:
- A finish that arrives during `S_BURST` is held in `flush_pending`. After the current burst, `S_IDLE` drains the remaining words with full bursts and then one partial burst.
- Words pushed during `S_BURST` are accepted normally. FIFO count updates for a simultaneous push and pop are net zero.
- Address arithmetic wraps modulo 2^`ADDR_SIZE`. No boundary check is performed.

## Timing
Reset values of all outputs:
- `req`=0, `addr`=`BASE_ADDR`, `len`=0, `o_WrDone`=0, `o_Overflow`=0, `o_PsumReady`=1.
- `o_burst_write_data`=0 (empty-FIFO head).

Latencies:
- `i_PsumValid` to FIFO occupancy: 2 cycles (pack register, then FIFO write).
- FIFO count reaching `BURST_LEN` to `req`=1: 1 cycle.
- `i_Psum_Finish` to `flush_pending`: 2 cycles.
- `i_burst_write_finish` to `req`=0: 1 cycle.
- Earliest next `req` after a finish: 2 cycles after that finish.

Handshake rules:
- `i_burst_write_valid` is never asserted by the responder when `req` is low. If the FIFO is empty during `S_BURST`, `valid` is ignored with no pop and no underflow.
- `s_rst` asserted mid-burst clears the FSM, FIFO pointers, flags and address on the next edge, with no further `req`.

## Test plan
- **Saturation:** push lanes {0x7FFFF, 0x80000, 0x00123, 0xFFFFE}. Written word must be 0xFFFE_0123_8000_7FFF (lane 3 down to lane 0: -2, 0x123, -32768, 32767).
- **Full bursts:** push 128 words with `BURST_LEN`=64. Expect two bursts: len 64 at `BASE_ADDR`, then len 64 at `BASE_ADDR`+512. The DDR model contents must equal the pushed sequence in order. No `o_WrDone`.
- **Partial flush:** push 70 words, then pulse `i_Psum_Finish`. Expect bursts of len 64 and then len 6 at +512, followed by a single `o_WrDone` pulse. Addr returns to `BASE_ADDR`.
- **Finish edge cases:**
  - Finish with an empty FIFO: `o_WrDone` 3 cycles after the finish, with no `req`.
  - Finish in the same cycle as the last valid: that word is included in the final burst.
- **Overflow:** stall `i_burst_write_valid` and push 130 words. Expect `o_PsumReady`=0 after 128 words, 2 words dropped, and `o_Overflow`=1 until reset.
- **Reset mid-burst:** assert `s_rst` after 10 beats of a 64-beat burst. Outputs return to their reset values next cycle. A fresh 64-word stream then writes from `BASE_ADDR`.
